// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider with a start/done handshake.
// One trial subtraction per clock; a divide takes WIDTH RUN cycles plus
// one FIN cycle, and a zero divisor goes straight to FIN.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      request, accepted when not in RUN (IDLE or FIN)
//   A, B       dividend / divisor, captured on the accepted start edge
//   Q, R       quotient / remainder, registered, held until next completion
//   busy       high while iterating
//   done       single-cycle completion pulse
//   DivByZero  set with done when the captured divisor was zero,
//              held until the next accepted start
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             DivByZero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned TW = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  // Partial remainder. Its (WIDTH+1)-th bit is always zero between
  // iterations because a kept difference is below the divisor, so only
  // WIDTH bits are stored; the widened value exists only in t_c.
  logic [WIDTH-1:0] p, p_d;
  logic [WIDTH-1:0] d, d_d;
  logic [WIDTH-1:0] b, b_d;
  logic [WIDTH-1:0] q_d, r_d;
  logic             dbz_d, busy_d, done_d;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  logic [TW-1:0]    t_c;
  logic [TW:0]      diff_c;
  logic             borrow_c;
  logic [WIDTH-1:0] p_iter_c;
  logic [WIDTH-1:0] d_iter_c;

  always_comb begin
    t_c      = {p, d[WIDTH-1]};
    diff_c   = {1'b0, t_c} - {2'b00, b};
    borrow_c = diff_c[TW];
    p_iter_c = borrow_c ? t_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
    d_iter_c = {d[WIDTH-2:0], ~borrow_c};
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    p_d     = p;
    d_d     = d;
    b_d     = b;
    q_d     = Q;
    r_d     = R;
    dbz_d   = DivByZero;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state)
      RUN: begin
        p_d    = p_iter_c;
        d_d    = d_iter_c;
        cnt_d  = cnt - CW'(1);
        busy_d = 1'b1;
        if (cnt == CW'(1)) begin
          state_d = FIN;
          q_d     = d_iter_c;
          r_d     = p_iter_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      IDLE, FIN: begin
        state_d = IDLE;
        if (start) begin
          b_d = B;
          d_d = A;
          p_d = '0;
          if (B != '0) begin
            state_d = RUN;
            cnt_d   = CW'(WIDTH);
            busy_d  = 1'b1;
            dbz_d   = 1'b0;
          end else begin
            state_d = FIN;
            cnt_d   = '0;
            q_d     = '1;
            r_d     = A;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      p         <= '0;
      d         <= '0;
      b         <= '0;
      Q         <= '0;
      R         <= '0;
      DivByZero <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      p         <= p_d;
      d         <= d_d;
      b         <= b_d;
      Q         <= q_d;
      R         <= r_d;
      DivByZero <= dbz_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule
